// File: rtl/imem_arbiter.sv
// Instruction-memory port arbiter: fetch has priority, an aging counter bounds loader starvation,
// and a lock mode hands the loader exclusive ownership. Responses are registered one cycle after grant.
module imem_arbiter #(
   parameter  int unsigned DEPTH_WORDS = 64,
   parameter  int unsigned MAX_WAIT    = 4,
   localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             f_req,
   input  logic [31:0]      f_addr,
   output logic             f_gnt,
   output logic             f_rvalid,
   output logic [31:0]      f_rdata,
   output logic             f_err,
   input  logic             l_req,
   input  logic             l_we,
   input  logic [31:0]      l_addr,
   input  logic [31:0]      l_wdata,
   input  logic             l_lock,
   output logic             l_gnt,
   output logic             l_rvalid,
   output logic [31:0]      l_rdata,
   output logic             l_err,
   output logic             locked,
   output logic [IDX_W-1:0] mem_addr,
   output logic             mem_we,
   output logic [31:0]      mem_wdata,
   input  logic [31:0]      mem_rdata
);

   localparam int unsigned      CNT_W    = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] MaxWaitC = CNT_W'(MAX_WAIT);
   localparam logic [31:0]      NopInsn  = 32'h0000_0013;

   typedef enum logic [0:0] {StRun, StLock} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             f_rvalid_q, l_rvalid_q, f_err_q, l_err_q;
   logic [31:0]      f_rdata_q, l_rdata_q;
   logic             f_bad, l_bad;

   // Misaligned, or beyond the last word (any set bit above the index field).
   function automatic logic addr_bad(input logic [31:0] a);
      return (a[1:0] != 2'b00) || ((a >> (IDX_W + 2)) != 32'd0);
   endfunction

   assign f_bad = addr_bad(f_addr);
   assign l_bad = addr_bad(l_addr);

   always_comb begin
      f_gnt = 1'b0;
      l_gnt = 1'b0;
      if (!rst) begin
         unique case (state_q)
            StRun: begin
               if (f_req && (!l_req || (wait_cnt_q != MaxWaitC))) begin
                  f_gnt = 1'b1;
               end else if (l_req) begin
                  l_gnt = 1'b1;
               end
            end
            StLock: l_gnt = l_req;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      unique case (state_q)
         StRun:   if (l_lock)  state_d = StLock;
         StLock:  if (!l_lock) state_d = StRun;
         default: state_d = StRun;
      endcase
      // Counter only ages in RUN while the loader is actually being refused.
      if ((state_q != StRun) || l_lock || !l_req || l_gnt) begin
         wait_cnt_d = '0;
      end else if (wait_cnt_q != MaxWaitC) begin
         wait_cnt_d = wait_cnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      mem_addr = '0;
      if (f_gnt) begin
         mem_addr = f_addr[IDX_W+1:2];
      end else if (l_gnt) begin
         mem_addr = l_addr[IDX_W+1:2];
      end
   end

   assign mem_we    = l_gnt & l_we & ~l_bad;
   assign mem_wdata = l_wdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StRun;
         wait_cnt_q <= '0;
         f_rvalid_q <= 1'b0;
         l_rvalid_q <= 1'b0;
         f_rdata_q  <= '0;
         l_rdata_q  <= '0;
         f_err_q    <= 1'b0;
         l_err_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         f_rvalid_q <= f_gnt;
         l_rvalid_q <= l_gnt;
         if (f_gnt) begin
            f_rdata_q <= f_bad ? NopInsn : mem_rdata;
            f_err_q   <= f_bad;
         end
         if (l_gnt) begin
            l_rdata_q <= (l_we || l_bad) ? 32'd0 : mem_rdata;
            l_err_q   <= l_bad;
         end
      end
   end

   assign f_rvalid = f_rvalid_q;
   assign f_rdata  = f_rdata_q;
   assign f_err    = f_err_q;
   assign l_rvalid = l_rvalid_q;
   assign l_rdata  = l_rdata_q;
   assign l_err    = l_err_q;
   assign locked   = (state_q == StLock);

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter: stimulus pushes expected responses, a monitor pops and
// compares on every rvalid.
module tb_imem_arbiter;

   localparam int unsigned DEPTH = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic        f_req, f_gnt, f_rvalid, f_err;
   logic [31:0] f_addr, f_rdata;
   logic        l_req, l_we, l_lock, l_gnt, l_rvalid, l_err;
   logic [31:0] l_addr, l_wdata, l_rdata;
   logic        locked, mem_we;
   logic [5:0]  mem_addr;
   logic [31:0] mem_wdata, mem_rdata;

   logic        pre_we;
   logic [5:0]  pre_addr;
   logic [31:0] pre_data;
   logic [31:0] mem [DEPTH];

   int          n_cmp = 0;
   int          n_fail = 0;
   logic [32:0] fq[$];
   logic [32:0] lq[$];

   imem_arbiter #(.DEPTH_WORDS(DEPTH), .MAX_WAIT(4)) dut (
      .clk(clk), .rst(rst),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
      .f_rdata(f_rdata), .f_err(f_err),
      .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_lock(l_lock),
      .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata), .l_err(l_err),
      .locked(locked), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Memory: combinational read, write at the clock edge; preload port used during reset.
   always @(posedge clk) begin
      if (pre_we) mem[pre_addr] <= pre_data;
      else if (mem_we) mem[mem_addr] <= mem_wdata;
   end
   assign mem_rdata = mem[mem_addr];

   task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (f_rvalid) begin
         if (fq.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL f_resp: got unexpected rvalid data %h, expected no response", f_rdata);
         end else chk("f_resp", {f_err, f_rdata}, fq.pop_front());
      end
      if (l_rvalid) begin
         if (lq.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL l_resp: got unexpected rvalid data %h, expected no response", l_rdata);
         end else chk("l_resp", {l_err, l_rdata}, lq.pop_front());
      end
   end

   // One cycle: check grants and mem_we mid-cycle, queue expected responses, advance.
   task automatic step(input string nm, input bit ef, input bit el,
                       input logic [32:0] fx, input logic [32:0] lx, input bit xwe);
      @(negedge clk);
      chk({nm, " f_gnt"}, {32'd0, f_gnt}, {32'd0, ef});
      chk({nm, " l_gnt"}, {32'd0, l_gnt}, {32'd0, el});
      chk({nm, " mem_we"}, {32'd0, mem_we}, {32'd0, xwe});
      if (ef) fq.push_back(fx);
      if (el) lq.push_back(lx);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; f_req = 1'b0; f_addr = '0; l_req = 1'b0; l_we = 1'b0;
      l_addr = '0; l_wdata = '0; l_lock = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
      for (int i = 0; i < 8; i++) begin
         pre_we   = 1'b1;
         pre_addr = 6'(i);
         pre_data = (i == 3) ? 32'hDEAD_BEEF : (32'hA000_0000 | 32'(i));
         @(posedge clk);
         #1;
      end
      pre_we = 1'b0;

      // Requests active during reset must not be granted.
      f_req = 1'b1; f_addr = 32'h0C; l_req = 1'b1; l_addr = 32'h10;
      @(negedge clk);
      chk("rst gnts", {31'd0, f_gnt, l_gnt}, 33'd0);
      chk("rst valids", {31'd0, f_rvalid, l_rvalid}, 33'd0);
      chk("rst errs", {31'd0, f_err, l_err}, 33'd0);
      chk("rst locked", {32'd0, locked}, 33'd0);
      chk("rst f_rdata", {1'b0, f_rdata}, 33'd0);
      chk("rst l_rdata", {1'b0, l_rdata}, 33'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #2;
      chk("post-rst valids", {31'd0, f_rvalid, l_rvalid}, 33'd0);

      // Both requesting continuously: F,F,F,F,L repeating.
      for (int i = 0; i < 10; i++) begin
         step("starve", !(i == 4 || i == 9), (i == 4 || i == 9),
              {1'b0, 32'hDEAD_BEEF}, {1'b0, 32'hA000_0004}, 1'b0);
      end
      chk("locked before", {32'd0, locked}, 33'd0);

      // Lock: the rising cycle still follows RUN rules, so fetch wins it.
      l_lock = 1'b1; l_we = 1'b1; l_addr = 32'h00; l_wdata = 32'h1111_1111;
      step("lock_rise", 1'b1, 1'b0, {1'b0, 32'hDEAD_BEEF}, 33'd0, 1'b0);
      chk("locked after rise", {32'd0, locked}, 33'd1);
      step("lock_w0", 1'b0, 1'b1, 33'd0, 33'd0, 1'b1);
      l_addr = 32'h04; l_wdata = 32'h2222_2222;
      step("lock_w1", 1'b0, 1'b1, 33'd0, 33'd0, 1'b1);
      l_lock = 1'b0; l_req = 1'b0; l_we = 1'b0; f_addr = 32'h04;
      step("lock_exit", 1'b0, 1'b0, 33'd0, 33'd0, 1'b0);
      chk("locked after exit", {32'd0, locked}, 33'd0);
      step("fetch_w1", 1'b1, 1'b0, {1'b0, 32'h2222_2222}, 33'd0, 1'b0);

      // Error handling.
      f_addr = 32'h02;
      step("f_misalign", 1'b1, 1'b0, {1'b1, 32'h0000_0013}, 33'd0, 1'b0);
      f_req = 1'b0;
      l_req = 1'b1; l_we = 1'b1; l_addr = 32'h100; l_wdata = 32'h5555_5555;
      step("l_oob_write", 1'b0, 1'b1, 33'd0, {1'b1, 32'd0}, 1'b0);
      l_we = 1'b0; l_addr = 32'h00;
      step("read_w0", 1'b0, 1'b1, 33'd0, {1'b0, 32'h1111_1111}, 1'b0);

      // Read immediately after write to the same word.
      l_we = 1'b1; l_addr = 32'h08; l_wdata = 32'hCAFE_F00D;
      step("raw_w", 1'b0, 1'b1, 33'd0, 33'd0, 1'b1);
      l_we = 1'b0;
      step("raw_r", 1'b0, 1'b1, 33'd0, {1'b0, 32'hCAFE_F00D}, 1'b0);
      l_req = 1'b0;
      step("idle0", 1'b0, 1'b0, 33'd0, 33'd0, 1'b0);
      step("idle1", 1'b0, 1'b0, 33'd0, 33'd0, 1'b0);

      chk("fq drained", 33'(fq.size()), 33'd0);
      chk("lq drained", 33'(lq.size()), 33'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
